// File: rtl/arb_out_pkg.sv
// Shared types and helpers for the arbiter output stage: skid FSM encoding,
// index-width helper and statistics counter width.
package arb_out_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } skid_state_e;

  localparam int unsigned STAT_W = 16;

  // Index width for n inputs, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_output_stage_route_idx_fifo.sv
// Routing FIFO of granted input indices; synchronous reset, flush clears it,
// push and pop in one cycle are allowed even when full.
module route_idx_fifo
  import arb_out_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [Width-1:0] data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = idx_width(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  cnt_q;
  logic [CntW-1:0]  cnt_d;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO may still push.
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    cnt_d   = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
      cnt_q <= cnt_d;
      empty <= (cnt_d == '0);
      full  <= (cnt_d == CntW'(Depth));
    end
  end

  // Storage needs no reset; empty masks the head.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) begin
      mem[wr_ptr] <= data;
    end
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/arb_output_stage.sv
// Arbiter output stage: 2-entry skid buffer onto the master channel plus a
// routing FIFO of winner indices. Optional per-input grant counters under
// ARB_OUT_STAGE_STATS_EN.
module arb_output_stage
  import arb_out_pkg::*;
#(
  parameter int unsigned NumIn      = 4,
  parameter type         DataType   = logic,
  parameter int unsigned RouteDepth = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         arb_req_i,
  input  DataType                      arb_data_i,
  input  logic [idx_width(NumIn)-1:0]  arb_idx_i,
  output logic                         arb_gnt_o,
  output logic                         mst_valid_o,
  input  logic                         mst_ready_i,
  output DataType                      mst_data_o,
  output logic                         route_valid_o,
  output logic [idx_width(NumIn)-1:0]  route_idx_o,
  input  logic                         route_pop_i,
  output logic                         route_full_o
`ifdef ARB_OUT_STAGE_STATS_EN
  ,
  output logic [STAT_W-1:0]            grant_cnt_o [NumIn]
`endif
);

  localparam int unsigned IdxW = idx_width(NumIn);

  skid_state_e state_q;
  skid_state_e state_d;
  DataType     spill_q;
  logic        acc;
  logic        drain;
  logic        load_main;
  logic        load_spill;
  logic        main_from_spill;
  logic        route_empty;

  // Grant ignores mst_ready_i; the full flag is the registered one.
  assign arb_gnt_o = arb_req_i & (state_q != TWO) & ~route_full_o & ~flush_i & ~rst_i;
  assign acc       = arb_req_i & arb_gnt_o;
  assign drain     = mst_valid_o & mst_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (acc) state_d = ONE;
      ONE: begin
        if (acc && !drain) begin
          state_d = TWO;
        end else if (!acc && drain) begin
          state_d = EMPTY;
        end
      end
      TWO:     if (drain) state_d = ONE;
      default: state_d = EMPTY;
    endcase
    if (flush_i) state_d = EMPTY;
  end

  // Register-load controls; main only changes when it is empty or draining.
  always_comb begin
    load_main       = 1'b0;
    load_spill      = 1'b0;
    main_from_spill = 1'b0;
    case (state_q)
      EMPTY: load_main = acc;
      ONE: begin
        load_main  = acc & drain;
        load_spill = acc & ~drain;
      end
      TWO: begin
        load_main       = drain;
        main_from_spill = 1'b1;
      end
      default: ;
    endcase
    if (flush_i) begin
      load_main  = 1'b0;
      load_spill = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mst_valid_o <= 1'b0;
      mst_data_o  <= '0;
      spill_q     <= '0;
    end else begin
      mst_valid_o <= (state_d != EMPTY);
      if (load_main) begin
        mst_data_o <= main_from_spill ? spill_q : arb_data_i;
      end
      if (load_spill) begin
        spill_q <= arb_data_i;
      end
    end
  end

  route_idx_fifo #(
    .Depth (RouteDepth),
    .Width (IdxW)
  ) u_route_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (flush_i),
    .push  (acc),
    .data  (arb_idx_i),
    .pop   (route_pop_i),
    .head  (route_idx_o),
    .empty (route_empty),
    .full  (route_full_o)
  );

  assign route_valid_o = ~route_empty;

`ifdef ARB_OUT_STAGE_STATS_EN
  // Saturating per-input accept counters.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NumIn; i++) begin
      if (rst_i || flush_i) begin
        grant_cnt_o[i] <= '0;
      end else if (acc && (arb_idx_i == IdxW'(i)) && (grant_cnt_o[i] != '1)) begin
        grant_cnt_o[i] <= grant_cnt_o[i] + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: doc/arb_output_stage.md
Name: arb_output_stage

Overview:
- Sits directly downstream of the fair round-robin arbiter in the AXI crossbar address path.
- Consumes the arbiter's winning req/data/idx and answers with the grant.
- Registers the winner into a valid/ready master channel through a 2-entry skid buffer.
- Pushes the winner's input index into a routing FIFO, so the W/data mux can follow address-grant order.

Parameters:
- NumIn, 4: number of arbitrated inputs; IdxW = $clog2(NumIn), min 1.
- DataType, logic: payload type carried from the arbiter.
- RouteDepth, 4: routing FIFO depth; power of two, >= 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- flush_i  in  1  drop all buffered beats and routing entries
- arb_req_i  in  1  arbiter has a winner
- arb_data_i  in  DataType  winner payload
- arb_idx_i  in  IdxW  winner input index
- arb_gnt_o  out  1  stage accepts winner this cycle
- mst_valid_o  out  1  master channel valid
- mst_ready_i  in  1  master channel ready
- mst_data_o  out  DataType  master channel payload
- route_valid_o  out  1  routing FIFO non-empty
- route_idx_o  out  IdxW  oldest routed index
- route_pop_i  in  1  W path finished the current burst; pop
- route_full_o  out  1  routing FIFO full

Behaviour:
- Interface (already decided): one clock, clk_i; rst_i is synchronous, active-high.
- Reset values:
  - mst_valid_o = 0, mst_data_o = '0.
  - route_valid_o = 0, route_idx_o = '0, route_full_o = 0.
  - arb_gnt_o = 0 during reset.
  - Skid state = EMPTY.
- Skid FSM states:
  - EMPTY: main register invalid.
  - ONE: main register valid.
  - TWO: main and spill registers both valid.
- Accept condition: acc = arb_req_i & arb_gnt_o.
- arb_gnt_o = arb_req_i & (state != TWO) & ~route_full_o & ~flush_i & ~rst_i. It is combinational and must not depend on mst_ready_i.
- Output handshake: drain = mst_valid_o & mst_ready_i.
- Transitions:
  - EMPTY & acc -> ONE; the main register loads arb_data_i.
  - ONE & acc & ~drain -> TWO; the spill register loads.
  - ONE & acc & drain -> ONE; main reloads with the new beat.
  - ONE & ~acc & drain -> EMPTY.
  - TWO & drain -> ONE; main takes the spill contents.
- Latency: accept in cycle N, mst_valid_o high in cycle N+1. Throughput is 1 beat/cycle while mst_ready_i = 1.
- mst_data_o is held stable while mst_valid_o & ~mst_ready_i.
- Routing FIFO:
  - Each acc pushes arb_idx_i.
  - A pop happens when route_pop_i & route_valid_o; route_pop_i while empty is ignored.
  - Push and pop in the same cycle leave the count unchanged, and this is allowed even when full.
  - Pointers wrap modulo RouteDepth; the count is IdxW-independent and RouteDepth+1 valued.
  - route_idx_o is '0 when empty.
- Full: route_full_o deasserts arb_gnt_o, and the arbiter holds its winner. A simultaneous pop does not re-enable the grant in the same cycle; it is registered-full only.
- Flush:
  - Next cycle: state EMPTY, FIFO empty, mst_valid_o = 0.
  - No accept during the flush cycle.
  - A flush overrides a simultaneous drain or pop.
- Reset mid-operation: all buffered beats and entries are discarded; no output glitches beyond the reset values.
- Beat order through the skid buffer and routing order are identical (FIFO order of acc).

Optional Feature:
- Macro: ARB_OUT_STAGE_STATS_EN.
- With the macro: adds output grant_cnt_o [NumIn][15:0]. It holds one saturating counter per input, incremented on acc at index arb_idx_i, holds at 16'hFFFF, and is cleared by rst_i or flush_i.
- Without the macro: the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package arb_out_pkg holds:
  - the skid_state_e enum (EMPTY = 2'b00, ONE = 2'b01, TWO = 2'b10);
  - the idx width function;
  - the counter width constant STAT_W = 16.
- Sub-module route_idx_fifo: synchronous-reset index FIFO with push, pop, full, empty, head outputs and a flush input. It is instantiated once.

Test Plan:
- Streaming: mst_ready_i = 1; arbiter winners idx 0,1,2,3 on consecutive cycles with data A,B,C,D.
  -> arb_gnt_o = 1 every cycle; mst_data_o A..D in cycles N+1..N+4; route_idx_o sequence 0,1,2,3.
- Backpressure: mst_ready_i = 0 after the first beat; 3 requests.
  -> Grants 2 beats and the state reaches TWO; the 3rd request is held (arb_gnt_o = 0).
  -> After ready = 1: beats emerge in order, with no loss or duplicate.
- Route full: RouteDepth = 4, no route_pop_i, 5 requests with mst_ready_i = 1.
  -> Exactly 4 grants; route_full_o = 1; the 5th is granted the cycle after the first pop.
- Simultaneous push/pop at full.
  -> Count stays 4; head advances; route_full_o stays 1.
- Flush with state TWO and FIFO holding 3 entries.
  -> Next cycle mst_valid_o = 0, route_valid_o = 0, arb_gnt_o = 0 during flush.
- Mid-burst reset: assert rst_i for 1 cycle while mst_valid_o = 1.
  -> All outputs are at reset values next cycle; the first post-reset accept appears on mst_data_o one cycle later.
  -> With ARB_OUT_STAGE_STATS_EN: counters read 0.
